// File: rtl/wb_regfile_if.sv
// wb_regfile_if: bundles the M/W stage inputs, the D-stage read ports and
// the write-back/retire observation outputs of the write-back register file.
// The pipeline side (master) drives the W-stage and read addresses; the
// register file (slave) returns read data, the write-back value and counters.
interface wb_regfile_if;
    logic [31:0] W_instr;
    logic [31:0] W_PC;
    logic [31:0] W_PCplus8;
    logic [4:0]  W_A3;
    logic [31:0] W_ALUres;
    logic [31:0] W_data;
    logic [4:0]  D_rs_addr;
    logic [4:0]  D_rt_addr;
    logic [31:0] D_rs_data;
    logic [31:0] D_rt_data;
    logic [31:0] W_wd;
    logic        W_we;
    logic [31:0] retire_cnt;

    modport master (
        output W_instr, W_PC, W_PCplus8, W_A3, W_ALUres, W_data,
        output D_rs_addr, D_rt_addr,
        input  D_rs_data, D_rt_data, W_wd, W_we, retire_cnt
    );

    modport slave (
        input  W_instr, W_PC, W_PCplus8, W_A3, W_ALUres, W_data,
        input  D_rs_addr, D_rt_addr,
        output D_rs_data, D_rt_data, W_wd, W_we, retire_cnt
    );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: MIPS write-back stage and 32x32 general register file.
// Selects the write-back value (ALU result, link address, or extended load
// data), commits it to the register file, serves two combinational read
// ports with same-cycle write-through bypass and counts retired
// (non-bubble) instructions.
// Optional feature macro: WB_TRACE_EN -- when defined, each committed write
// prints "@<pc>: $<reg> <= <value>" in simulation.
module wb_regfile (
    input logic          clk,
    input logic          reset,
    wb_regfile_if.slave  bus
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] FN_JALR    = 6'h09;

    typedef enum logic [2:0] {
        SEL_ALU,
        SEL_LINK,
        SEL_WORD,
        SEL_BYTE,
        SEL_HALF
    } wb_sel_e;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [1:0]  off;
    wb_sel_e     sel;
    logic        sext;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] wd;
    logic        we;

    logic [31:0] regs_q [32];
    logic [31:0] retire_cnt_q;
    logic [31:0] retire_cnt_d;

    assign op    = bus.W_instr[31:26];
    assign funct = bus.W_instr[5:0];
    assign off   = bus.W_ALUres[1:0];

    // Decode the W-stage opcode into a write-back source and extension mode.
    always_comb begin
        sel  = SEL_ALU;
        sext = 1'b0;
        unique case (op)
            OP_JAL:  sel = SEL_LINK;
            OP_LW:   sel = SEL_WORD;
            OP_LB:   begin sel = SEL_BYTE; sext = 1'b1; end
            OP_LBU:  sel = SEL_BYTE;
            OP_LH:   begin sel = SEL_HALF; sext = 1'b1; end
            OP_LHU:  sel = SEL_HALF;
            OP_SPECIAL: begin
                if (funct == FN_JALR) begin
                    sel = SEL_LINK;
                end
            end
            default: sel = SEL_ALU;
        endcase
    end

    // Lane extraction for sub-word loads; the half lane ignores the low
    // address bit so a misaligned half simply reads the enclosing half.
    always_comb begin
        load_byte = bus.W_data[7:0];
        unique case (off)
            2'b00: load_byte = bus.W_data[7:0];
            2'b01: load_byte = bus.W_data[15:8];
            2'b10: load_byte = bus.W_data[23:16];
            2'b11: load_byte = bus.W_data[31:24];
            default: load_byte = bus.W_data[7:0];
        endcase
        load_half = off[1] ? bus.W_data[31:16] : bus.W_data[15:0];
    end

    // Write-back value multiplexer with sign/zero extension.
    always_comb begin
        wd = bus.W_ALUres;
        unique case (sel)
            SEL_LINK: wd = bus.W_PCplus8;
            SEL_WORD: wd = bus.W_data;
            SEL_BYTE: wd = {{24{sext & load_byte[7]}}, load_byte};
            SEL_HALF: wd = {{16{sext & load_half[15]}}, load_half};
            default:  wd = bus.W_ALUres;
        endcase
    end

    // $0 is never a target, and reset suppresses the write of the
    // instruction presented alongside it.
    assign we = (bus.W_A3 != 5'd0) && !reset;

    assign bus.W_wd = wd;
    assign bus.W_we = we;

    // Register array: synchronous clear, then one write port. Entry 0 is
    // only ever cleared; the read ports force it to zero regardless.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else if (we) begin
            regs_q[bus.W_A3] <= wd;
        end
    end

    // Read port 1: $0 forced to zero, bypass of the value being written.
    always_comb begin
        if (bus.D_rs_addr == 5'd0) begin
            bus.D_rs_data = 32'h0;
        end else if (we && (bus.D_rs_addr == bus.W_A3)) begin
            bus.D_rs_data = wd;
        end else begin
            bus.D_rs_data = regs_q[bus.D_rs_addr];
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        if (bus.D_rt_addr == 5'd0) begin
            bus.D_rt_data = 32'h0;
        end else if (we && (bus.D_rt_addr == bus.W_A3)) begin
            bus.D_rt_data = wd;
        end else begin
            bus.D_rt_data = regs_q[bus.D_rt_addr];
        end
    end

    // Next retire count: any non-bubble instruction counts, stores included;
    // the adder wraps naturally at 32 bits.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (bus.W_instr != 32'h0) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    // Retire counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt_q <= 32'h0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign bus.retire_cnt = retire_cnt_q;

`ifdef WB_TRACE_EN
    // Commit trace, one line per architectural register write.
    always_ff @(posedge clk) begin
        if (we) begin
            $display("@%h: $%d <= %h", bus.W_PC, bus.W_A3, wd);
        end
    end
`else
    // The PC is carried only for the commit trace.
    logic unused_pc;
    assign unused_pc = ^bus.W_PC;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed cases from the block's test plan followed by
// randomized W-stage traffic, all checked against an array-based reference
// model of the register file, write-back selection and retire counter.
module tb_wb_regfile;

    logic clk;
    logic reset;

    wb_regfile_if bus ();

    wb_regfile dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
        return {op, 20'h1A2B3, fn};
    endfunction

    // Reference write-back value from the ISA load/link rules.
    function automatic logic [31:0] ref_wd(input logic [31:0] instr, input logic [31:0] pcp8,
                                           input logic [31:0] alures, input logic [31:0] data);
        logic [5:0]  op;
        logic [5:0]  fn;
        int          boff;
        int          hoff;
        logic [7:0]  b;
        logic [15:0] h;
        op   = instr[31:26];
        fn   = instr[5:0];
        boff = int'(alures[1:0]) * 8;
        hoff = int'(alures[1]) * 16;
        b    = 8'(data >> boff);
        h    = 16'(data >> hoff);
        if (op == 6'h03 || (op == 6'h00 && fn == 6'h09)) return pcp8;
        case (op)
            6'h23:   return data;
            6'h20:   return 32'($signed(b));
            6'h24:   return 32'(b);
            6'h21:   return 32'($signed(h));
            6'h25:   return 32'(h);
            default: return alures;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] addr);
        logic we;
        we = (bus.W_A3 != 0) && !reset;
        if (addr == 0) return 32'h0;
        if (we && addr == bus.W_A3)
            return ref_wd(bus.W_instr, bus.W_PCplus8, bus.W_ALUres, bus.W_data);
        return m_regs[addr];
    endfunction

    task automatic drive(input logic rst, input logic [31:0] instr, input logic [31:0] pcp8,
                         input logic [31:0] alures, input logic [31:0] data,
                         input logic [4:0] a3, input logic [4:0] rs, input logic [4:0] rt);
        reset         = rst;
        bus.W_instr   = instr;
        bus.W_PC      = pcp8 - 32'd8;
        bus.W_PCplus8 = pcp8;
        bus.W_ALUres  = alures;
        bus.W_data    = data;
        bus.W_A3      = a3;
        bus.D_rs_addr = rs;
        bus.D_rt_addr = rt;
        #1;
    endtask

    task automatic check_model();
        check("W_wd", bus.W_wd, ref_wd(bus.W_instr, bus.W_PCplus8, bus.W_ALUres, bus.W_data));
        check("W_we", 32'(bus.W_we), 32'((bus.W_A3 != 0) && !reset));
        check("rs_data", bus.D_rs_data, ref_read(bus.D_rs_addr));
        check("rt_data", bus.D_rt_data, ref_read(bus.D_rt_addr));
        check("retire_cnt", bus.retire_cnt, m_cnt);
    endtask

    // Advance one clock and apply the architectural effect of the cycle.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_cnt = 32'h0;
        end else begin
            if (bus.W_A3 != 0)
                m_regs[bus.W_A3] = ref_wd(bus.W_instr, bus.W_PCplus8, bus.W_ALUres, bus.W_data);
            if (bus.W_instr != 0) m_cnt = m_cnt + 32'd1;
        end
        @(negedge clk);
    endtask

    localparam logic [5:0] RAND_OPS [9] = '{6'h00, 6'h03, 6'h00, 6'h23, 6'h20,
                                            6'h24, 6'h21, 6'h25, 6'h0D};

    initial begin
        logic [31:0] instr;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  a3;
        int          k;
        n_cmp = 0;
        n_err = 0;
        m_cnt = 32'h0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);

        // Reset, then read back cleared entries.
        drive(1'b1, 32'h0, 32'h8, 32'h0, 32'h0, 5'd0, 5'd5, 5'd31);
        tick();
        drive(1'b0, 32'h0, 32'h8, 32'h0, 32'h0, 5'd0, 5'd5, 5'd31);
        check("rst_r5", bus.D_rs_data, 32'h0);
        check("rst_r31", bus.D_rt_data, 32'h0);
        check("rst_cnt", bus.retire_cnt, 32'h0);
        check_model();
        tick();

        // ALU write with same-cycle bypass, then from the array.
        drive(1'b0, mk(6'h00, 6'h21), 32'h108, 32'h1234_5678, 32'h0, 5'd8, 5'd8, 5'd0);
        check("bypass_rs", bus.D_rs_data, 32'h1234_5678);
        check_model();
        tick();
        drive(1'b0, 32'h0, 32'h110, 32'h0, 32'h0, 5'd0, 5'd8, 5'd0);
        check("stored_rs", bus.D_rs_data, 32'h1234_5678);
        check("cnt_one", bus.retire_cnt, 32'd1);
        check_model();
        tick();

        // $0 protection.
        drive(1'b0, mk(6'h00, 6'h21), 32'h118, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd0);
        check("r0_we", 32'(bus.W_we), 32'h0);
        check("r0_rt", bus.D_rt_data, 32'h0);
        check_model();
        tick();

        // Load extension cases.
        drive(1'b0, mk(6'h20, 6'h00), 32'h120, 32'h0000_1003, 32'h80FF_7F01, 5'd12, 5'd12, 5'd0);
        check("lb_off3", bus.W_wd, 32'hFFFF_FF80);
        check_model();
        tick();
        drive(1'b0, mk(6'h24, 6'h00), 32'h128, 32'h0000_1003, 32'h80FF_7F01, 5'd13, 5'd12, 5'd13);
        check("lbu_off3", bus.W_wd, 32'h0000_0080);
        check_model();
        tick();
        drive(1'b0, mk(6'h21, 6'h00), 32'h130, 32'h0000_1000, 32'h80FF_7F01, 5'd14, 5'd13, 5'd14);
        check("lh_off0", bus.W_wd, 32'h0000_7F01);
        check_model();
        tick();
        drive(1'b0, mk(6'h25, 6'h00), 32'h138, 32'h0000_1000, 32'h80FF_7F01, 5'd15, 5'd14, 5'd15);
        check("lhu_off0", bus.W_wd, 32'h0000_7F01);
        check_model();
        tick();
        drive(1'b0, mk(6'h21, 6'h00), 32'h140, 32'h0000_1002, 32'h80FF_7F01, 5'd16, 5'd15, 5'd16);
        check("lh_off2", bus.W_wd, 32'hFFFF_80FF);
        check_model();
        tick();

        // Link writes.
        drive(1'b0, mk(6'h03, 6'h00), 32'h0000_3008, 32'hAAAA_0000, 32'h0, 5'd31, 5'd0, 5'd0);
        check_model();
        tick();
        drive(1'b0, mk(6'h00, 6'h09), 32'h0000_4444, 32'hBBBB_0000, 32'h0, 5'd4, 5'd31, 5'd4);
        check("jalr_bypass", bus.D_rt_data, 32'h0000_4444);
        check_model();
        tick();
        drive(1'b0, 32'h0, 32'h150, 32'h0, 32'h0, 5'd0, 5'd31, 5'd4);
        check("jal_r31", bus.D_rs_data, 32'h0000_3008);
        check("jalr_r4", bus.D_rt_data, 32'h0000_4444);
        check_model();
        tick();

        // Both ports on the destination.
        drive(1'b0, mk(6'h0D, 6'h00), 32'h158, 32'h0BAD_CAFE, 32'h0, 5'd7, 5'd7, 5'd7);
        check("dual_rs", bus.D_rs_data, 32'h0BAD_CAFE);
        check("dual_rt", bus.D_rt_data, 32'h0BAD_CAFE);
        check_model();
        tick();

        // Reset mid-stream: $9 holds a value, then a lw to $9 arrives with reset.
        drive(1'b0, mk(6'h00, 6'h21), 32'h160, 32'h0000_0099, 32'h0, 5'd9, 5'd0, 5'd0);
        check_model();
        tick();
        drive(1'b1, mk(6'h23, 6'h00), 32'h168, 32'h0000_2000, 32'hDEAD_BEEF, 5'd9, 5'd9, 5'd7);
        check("rstmid_we", 32'(bus.W_we), 32'h0);
        check("rstmid_pre", bus.D_rs_data, 32'h0000_0099);
        check_model();
        tick();
        drive(1'b0, 32'h0, 32'h170, 32'h0, 32'h0, 5'd0, 5'd9, 5'd7);
        check("rstmid_r9", bus.D_rs_data, 32'h0);
        check("rstmid_cnt", bus.retire_cnt, 32'h0);
        check_model();
        tick();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            k  = int'($urandom_range(0, 8));
            op = RAND_OPS[k];
            fn = (k == 2) ? 6'h09 : 6'($urandom_range(0, 63));
            instr = {op, 20'($urandom), fn};
            a3 = 5'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                instr = 32'h0;
                a3    = 5'd0;
            end
            drive(($urandom_range(0, 49) == 0), instr, $urandom, $urandom, $urandom, a3,
                  ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom),
                  ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom));
            check_model();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and general register file for the five-stage MIPS pipeline. It consumes the M/W pipeline register outputs (instruction, PC, PC+8, destination register, ALU result, raw memory word) and selects the write-back value, applying byte/half extension for loads. It commits that value to a 32x32 register file and serves the two D-stage read ports with internal write-through bypass. It also keeps a retired-instruction counter.

## Interface

Parameters:
- none

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  reset, synchronous, active-high
- W_instr  input  32  instruction in W stage; 32'h0 = bubble
- W_PC  input  32  PC of W instruction (trace only)
- W_PCplus8  input  32  link value for jal/jalr
- W_A3  input  5  destination register; 0 = no write
- W_ALUres  input  32  ALU result / load address
- W_data  input  32  raw aligned word read from data memory
- D_rs_addr  input  5  read port 1 address
- D_rt_addr  input  5  read port 2 address
- D_rs_data  output  32  read port 1 data (combinational)
- D_rt_data  output  32  read port 2 data (combinational)
- W_wd  output  32  selected write-back value, for forwarding to E/M
- W_we  output  1  write enable actually applied this cycle
- retire_cnt  output  32  count of non-bubble instructions retired

## Operation

- Decode: op = W_instr[31:26], funct = W_instr[5:0], off = W_ALUres[1:0].
- Write-back select:
  - jal (op 6'h03) or jalr (op 0, funct 6'h09): W_PCplus8.
  - lw (6'h23): W_data.
  - lb (6'h20) / lbu (6'h24): byte W_data[8*off+7 : 8*off], sign- / zero-extended.
  - lh (6'h21) / lhu (6'h25): half W_data[16*off[1]+15 : 16*off[1]], sign- / zero-extended; off[0] ignored.
  - all others: W_ALUres.
- W_we = (W_A3 != 0) and not reset. W_wd is driven regardless of W_we.
- Register file: 32 entries x 32 bits; entry 0 is never written and always reads 0.
- Reads, per port: if addr == 0, return 0. Else if W_we and addr == W_A3, return W_wd (bypass). Else return the stored entry.
- retire_cnt increments by 1 on each cycle with W_instr != 0 and not reset. It wraps from 32'hFFFFFFFF to 0.

## Timing

- Write latency: the value is visible in the array after the rising edge of the cycle W_we is high. Via bypass it is visible on the read ports in that same cycle.
- Read ports, W_wd and W_we are purely combinational. There is no read latency.
- Reset: on a rising edge with reset high, all 32 entries are set to 0 and retire_cnt to 0. No write occurs in that cycle, and a W instruction present during reset is not counted.
- Outputs during reset: W_we = 0 and D_*_data reflect stored (pre-reset) values until the edge, then 0.
- Both read ports may address W_A3 simultaneously; both are bypassed.
- Bubble (W_instr = 0, W_A3 = 0): no write, no count.
- A non-zero instruction with W_A3 = 0 (e.g. a store) is counted but writes nothing.

## Configuration

- WB_TRACE_EN defined: on every rising edge with W_we high and reset low, the block emits the simulation print "@%h: $%d <= %h" with W_PC, W_A3 and W_wd, using 8-digit hex and 2-digit decimal.
- WB_TRACE_EN undefined: no print statements are compiled. Functional behaviour is identical.

## Test plan

- Reset then read: assert reset 1 cycle, then read addr 5 and 31 -> both 32'h0. retire_cnt = 0.
- ALU write + bypass: W_instr = addu, W_A3 = 8, W_ALUres = 32'h1234_5678, D_rs_addr = 8 in the same cycle -> D_rs_data = 32'h1234_5678 before the edge. After the edge it stays the same with no W activity, and retire_cnt = 1.
- $0 protection: W_A3 = 0, W_ALUres = 32'hFFFF_FFFF, D_rt_addr = 0 -> W_we = 0, D_rt_data = 0.
- Load extension: W_data = 32'h80FF_7F01, W_ALUres[1:0] = 2'b11. lb -> 32'hFFFF_FF80, lbu -> 32'h0000_0080. With offset 2'b00, lh -> 32'h0000_7F01 and lhu -> 32'h0000_7F01. With offset 2'b10, lh -> 32'hFFFF_80FF.
- Link write: jal with W_A3 = 31, W_PCplus8 = 32'h0000_3008 -> $31 = 32'h0000_3008. A jalr with W_A3 = 4 writes W_PCplus8 to $4.
- Reset mid-stream: a valid lw with W_A3 = 9 presented in the same cycle as reset -> $9 = 0 after the edge, retire_cnt = 0. With WB_TRACE_EN defined, no print is emitted for that cycle.
